// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
package int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } int_state_e;

   localparam logic [31:0] INT_VEC_BASE   = 32'h0000_01F0;
   localparam int          INT_VEC_STRIDE = 4;
   localparam int          INT_NUM_SRC    = 4;

   // Byte address of the vector slot for a given source; wraps silently at 32 bits.
   function automatic logic [31:0] int_vec_addr(input logic [31:0] base,
                                                input logic [31:0] stride,
                                                input logic [31:0] id);
      return base + id * stride;
   endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module int_prio_enc #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] eligible,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   always_comb begin
      valid = |eligible;
      id    = '0;
      // Scan downward so the last assignment is the lowest index.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) id = ID_W'(i);
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Vectored, non-nesting interrupt controller with edge-latched pending events.
// Optional `INT_CTRL_SYNC_EN adds a two-flop synchronizer on irq_in.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int          NUM_SRC    = INT_NUM_SRC,
   parameter logic [31:0] VEC_BASE   = INT_VEC_BASE,
   parameter int          VEC_STRIDE = INT_VEC_STRIDE,
   parameter int          ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               int_en,
   input  logic               int_ack,
   input  logic               int_done,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wd,
   output logic               int_req,
   output logic [31:0]        vec_addr,
   output logic [ID_W-1:0]    int_id,
   output logic [NUM_SRC-1:0] pending,
   output logic               in_service
);

   int_state_e         state, state_nxt;
   logic [NUM_SRC-1:0] irq_src;
   logic [NUM_SRC-1:0] irq_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] pending_nxt;
   logic               win_vld;
   logic [ID_W-1:0]    win_id;
   logic               int_req_nxt;
   logic [31:0]        vec_addr_nxt;
   logic [ID_W-1:0]    int_id_nxt;
   logic               in_service_nxt;

`ifdef INT_CTRL_SYNC_EN
   logic [NUM_SRC-1:0] irq_s1, irq_s2;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         irq_s1 <= '0;
         irq_s2 <= '0;
      end else begin
         irq_s1 <= irq_in;
         irq_s2 <= irq_s1;
      end
   end

   assign irq_src = irq_s2;
`else
   assign irq_src = irq_in;
`endif

   assign rise = irq_src & ~irq_d;

   int_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio (
      .eligible (pending & mask),
      .valid    (win_vld),
      .id       (win_id)
   );

   always_comb begin
      state_nxt      = state;
      int_req_nxt    = int_req;
      vec_addr_nxt   = vec_addr;
      int_id_nxt     = int_id;
      in_service_nxt = in_service;
      clr            = '0;
      case (state)
         IDLE: begin
            if (int_en && win_vld) begin
               int_id_nxt   = win_id;
               vec_addr_nxt = int_vec_addr(VEC_BASE, 32'(VEC_STRIDE), 32'(win_id));
               int_req_nxt  = 1'b1;
               state_nxt    = REQ;
            end
         end
         REQ: begin
            // Acknowledge beats a simultaneous enable drop.
            if (int_ack) begin
               clr[int_id]    = 1'b1;
               int_req_nxt    = 1'b0;
               in_service_nxt = 1'b1;
               state_nxt      = SERVICE;
            end else if (!int_en) begin
               int_req_nxt = 1'b0;
               state_nxt   = IDLE;
            end
         end
         SERVICE: begin
            if (int_done) begin
               in_service_nxt = 1'b0;
               state_nxt      = IDLE;
            end
         end
         default: begin
            int_req_nxt    = 1'b0;
            in_service_nxt = 1'b0;
            state_nxt      = IDLE;
         end
      endcase
      // A new edge on the bit being cleared wins.
      pending_nxt = (pending & ~clr) | rise;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= IDLE;
         irq_d      <= '0;
         mask       <= '1;
         pending    <= '0;
         int_req    <= 1'b0;
         vec_addr   <= '0;
         int_id     <= '0;
         in_service <= 1'b0;
      end else begin
         state      <= state_nxt;
         irq_d      <= irq_src;
         pending    <= pending_nxt;
         int_req    <= int_req_nxt;
         vec_addr   <= vec_addr_nxt;
         int_id     <= int_id_nxt;
         in_service <= in_service_nxt;
         if (mask_we) mask <= mask_wd;
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl (default build, no input synchronizer).
module tb_int_ctrl;

   logic        Clk;
   logic        Rst;
   logic [3:0]  irq_in;
   logic        int_en;
   logic        int_ack;
   logic        int_done;
   logic        mask_we;
   logic [3:0]  mask_wd;
   logic        int_req;
   logic [31:0] vec_addr;
   logic [1:0]  int_id;
   logic [3:0]  pending;
   logic        in_service;

   int checks = 0;
   int errors = 0;

   int_ctrl dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .irq_in     (irq_in),
      .int_en     (int_en),
      .int_ack    (int_ack),
      .int_done   (int_done),
      .mask_we    (mask_we),
      .mask_wd    (mask_wd),
      .int_req    (int_req),
      .vec_addr   (vec_addr),
      .int_id     (int_id),
      .pending    (pending),
      .in_service (in_service)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_irq(input logic [3:0] v);
      irq_in = v;
      tick();
      irq_in = 4'b0000;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic done();
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b0; irq_in = '0; int_en = 1'b1; int_ack = 1'b0; int_done = 1'b0;
      mask_we = 1'b0; mask_wd = '0;
      #3;
      checks++;
      if ({int_req, in_service, int_id, pending, vec_addr} !== 40'd0) begin
         errors++;
         $display("FAIL reset_outputs req=%0b svc=%0b id=%0d pend=%b vec=%h required all zero",
                  int_req, in_service, int_id, pending, vec_addr);
      end
      tick();
      Rst = 1'b1;
      tick();
      checks++;
      if (int_req !== 1'b0 || pending !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release req=%0b pend=%b required req=0 pend=0000", int_req, pending);
      end
   endtask

   task automatic test_single();
      pulse_irq(4'b0001);
      checks++;
      if (pending !== 4'b0001 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL single_latch pend=%b req=%0b required pend=0001 req=0", pending, int_req);
      end
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd0 || vec_addr !== 32'h1F0) begin
         errors++;
         $display("FAIL single_req req=%0b id=%0d vec=%h required 1/0/1f0", int_req, int_id, vec_addr);
      end
      ack();
      checks++;
      if (int_req !== 1'b0 || pending !== 4'b0000 || in_service !== 1'b1) begin
         errors++;
         $display("FAIL single_ack req=%0b pend=%b svc=%0b required 0/0000/1", int_req, pending, in_service);
      end
      done();
      checks++;
      if (in_service !== 1'b0 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL single_done svc=%0b req=%0b required 0/0", in_service, int_req);
      end
      tick();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL single_idle req=%0b required 0", int_req);
      end
   endtask

   task automatic test_priority();
      pulse_irq(4'b1010);
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd1 || vec_addr !== 32'h1F4) begin
         errors++;
         $display("FAIL prio_first req=%0b id=%0d vec=%h required 1/1/1f4", int_req, int_id, vec_addr);
      end
      ack();
      checks++;
      if (pending !== 4'b1000) begin
         errors++;
         $display("FAIL prio_pend pend=%b required 1000", pending);
      end
      done();
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd3 || vec_addr !== 32'h1FC) begin
         errors++;
         $display("FAIL prio_second req=%0b id=%0d vec=%h required 1/3/1fc", int_req, int_id, vec_addr);
      end
      ack();
      done();
   endtask

   task automatic test_non_nesting();
      pulse_irq(4'b0100);
      tick();
      ack();
      checks++;
      if (in_service !== 1'b1) begin
         errors++;
         $display("FAIL nest_svc svc=%0b required 1", in_service);
      end
      pulse_irq(4'b0001);
      tick();
      tick();
      checks++;
      if (int_req !== 1'b0 || pending !== 4'b0001) begin
         errors++;
         $display("FAIL nest_blocked req=%0b pend=%b required 0/0001", int_req, pending);
      end
      done();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL nest_done req=%0b required 0", int_req);
      end
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd0) begin
         errors++;
         $display("FAIL nest_after req=%0b id=%0d required 1/0", int_req, int_id);
      end
      ack();
      done();
   endtask

   task automatic test_mask();
      mask_we = 1'b1; mask_wd = 4'b1110;
      tick();
      mask_we = 1'b0;
      pulse_irq(4'b0001);
      tick();
      tick();
      checks++;
      if (int_req !== 1'b0 || pending !== 4'b0001) begin
         errors++;
         $display("FAIL mask_blocked req=%0b pend=%b required 0/0001", int_req, pending);
      end
      mask_we = 1'b1; mask_wd = 4'b1111;
      tick();
      mask_we = 1'b0;
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd0) begin
         errors++;
         $display("FAIL mask_unmask req=%0b id=%0d required 1/0", int_req, int_id);
      end
      ack();
      done();
   endtask

   task automatic test_enable_drop();
      pulse_irq(4'b0010);
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd1) begin
         errors++;
         $display("FAIL en_req req=%0b id=%0d required 1/1", int_req, int_id);
      end
      int_en = 1'b0;
      tick();
      checks++;
      if (int_req !== 1'b0 || pending !== 4'b0010) begin
         errors++;
         $display("FAIL en_withdraw req=%0b pend=%b required 0/0010", int_req, pending);
      end
      tick();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL en_hold req=%0b required 0", int_req);
      end
      int_en = 1'b1;
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd1 || vec_addr !== 32'h1F4) begin
         errors++;
         $display("FAIL en_rearm req=%0b id=%0d vec=%h required 1/1/1f4", int_req, int_id, vec_addr);
      end
      ack();
      done();
   endtask

   task automatic test_collision();
      pulse_irq(4'b0100);
      tick();
      irq_in = 4'b0100;
      int_ack = 1'b1;
      tick();
      irq_in = 4'b0000;
      int_ack = 1'b0;
      checks++;
      if (pending !== 4'b0100 || in_service !== 1'b1 || int_req !== 1'b0) begin
         errors++;
         $display("FAIL collide_set pend=%b svc=%0b req=%0b required 0100/1/0", pending, in_service, int_req);
      end
      done();
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd2 || vec_addr !== 32'h1F8) begin
         errors++;
         $display("FAIL collide_again req=%0b id=%0d vec=%h required 1/2/1f8", int_req, int_id, vec_addr);
      end
      ack();
      done();
   endtask

   task automatic test_reset_mid_service();
      pulse_irq(4'b0001);
      tick();
      ack();
      pulse_irq(4'b0100);
      tick();
      checks++;
      if (in_service !== 1'b1 || pending !== 4'b0100) begin
         errors++;
         $display("FAIL rst_setup svc=%0b pend=%b required 1/0100", in_service, pending);
      end
      #2;
      Rst = 1'b0;
      #1;
      checks++;
      if ({int_req, in_service, int_id, pending, vec_addr} !== 40'd0) begin
         errors++;
         $display("FAIL rst_async req=%0b svc=%0b id=%0d pend=%b vec=%h required all zero",
                  int_req, in_service, int_id, pending, vec_addr);
      end
      #1;
      Rst = 1'b1;
      tick();
      pulse_irq(4'b1000);
      tick();
      checks++;
      if (int_req !== 1'b1 || int_id !== 2'd3 || vec_addr !== 32'h1FC) begin
         errors++;
         $display("FAIL rst_mask_ones req=%0b id=%0d vec=%h required 1/3/1fc", int_req, int_id, vec_addr);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_non_nesting();
      test_mask();
      test_enable_drop();
      test_collision();
      test_reset_mid_service();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
